// File: rtl/yarvi_mtimer.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime/mtimecmp, prescaled tick,
// enable control and a level timer interrupt for mip[7].
module yarvi_mtimer #(
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        bus_req_ready,
  input  logic        bus_req_read,
  input  logic        bus_req_write,
  input  logic [31:0] bus_req_address,
  input  logic [31:0] bus_req_data,
  output logic        bus_res_valid,
  output logic [31:0] bus_res_data,
  output logic        timer_irq,
  output logic [31:0] mtime_lo
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic        r_boot;
  logic        r_ready;
  logic        r_res_valid;
  logic [31:0] r_res_data;
  logic        r_irq;
  logic        r_enable;
  logic [15:0] r_presc;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;

  logic        w_hit;
  logic [2:0]  w_sel;
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic        w_wr_mlo;
  logic        w_wr_mhi;
  logic        w_wr_clo;
  logic        w_wr_chi;
  logic        w_wr_ctrl;
  logic        w_disable;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  // Byte lane bits are don't-care: every register is a full word.
  assign w_unused_addr = &{1'b0, bus_req_address[1:0]};

  assign w_hit     = (bus_req_address[31:5] == BASE[31:5]);
  assign w_sel     = bus_req_address[4:2];
  assign w_accept  = r_ready && (bus_req_read || bus_req_write);
  assign w_wr      = w_accept && bus_req_write;
  assign w_rd      = w_accept && bus_req_read && !bus_req_write;
  assign w_tick    = r_enable && (r_presc == PS_LAST);

  assign w_wr_mlo  = w_wr && w_hit && (w_sel == 3'd0);
  assign w_wr_mhi  = w_wr && w_hit && (w_sel == 3'd1);
  assign w_wr_clo  = w_wr && w_hit && (w_sel == 3'd2);
  assign w_wr_chi  = w_wr && w_hit && (w_sel == 3'd3);
  assign w_wr_ctrl = w_wr && w_hit && (w_sel == 3'd4);
  assign w_disable = w_wr_ctrl && !bus_req_data[0];

  always_comb begin
    w_rdata = 32'h0;
    if (w_hit) begin
      case (w_sel)
        3'd0:    w_rdata = r_mtime[31:0];
        3'd1:    w_rdata = r_mtime[63:32];
        3'd2:    w_rdata = r_mtimecmp[31:0];
        3'd3:    w_rdata = r_mtimecmp[63:32];
        3'd4:    w_rdata = {31'h0, r_enable};
        default: w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_boot      <= 1'b0;
      r_ready     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 32'h0;
      r_irq       <= 1'b0;
      r_enable    <= 1'b0;
      r_presc     <= 16'h0;
      r_mtime     <= 64'h0;
      r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      r_boot      <= 1'b1;
      r_ready     <= r_boot;
      r_res_valid <= w_rd;
      if (w_rd) r_res_data <= w_rdata;

      r_irq <= r_enable && (r_mtime >= r_mtimecmp);

      if (!r_enable || w_disable || w_tick) r_presc <= 16'h0;
      else                                 r_presc <= r_presc + 16'd1;

      // A software write to either mtime half overrides that cycle's tick.
      if (w_wr_mlo)      r_mtime[31:0]  <= bus_req_data;
      else if (w_wr_mhi) r_mtime[63:32] <= bus_req_data;
      else if (w_tick)   r_mtime        <= r_mtime + 64'd1;

      if (w_wr_clo)  r_mtimecmp[31:0]  <= bus_req_data;
      if (w_wr_chi)  r_mtimecmp[63:32] <= bus_req_data;
      if (w_wr_ctrl) r_enable          <= bus_req_data[0];
    end
  end

  assign bus_req_ready = r_ready;
  assign bus_res_valid = r_res_valid;
  assign bus_res_data  = r_res_data;
  assign timer_irq     = r_irq;
  assign mtime_lo      = r_mtime[31:0];

endmodule

// File: tb/tb_yarvi_mtimer.sv
// Scoreboard bench for yarvi_mtimer: DUT0 runs PRESCALE=1, DUT1 runs PRESCALE=4.
module tb_yarvi_mtimer;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    int          dut;
    logic [31:0] off;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready [2];
  logic        valid [2];
  logic [31:0] rdata [2];
  logic        irq [2];
  logic [31:0] mlo [2];

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clock = ~clock;

  yarvi_mtimer #(.BASE(BASE), .PRESCALE(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus_req_ready(ready[0]),
    .bus_req_read(rd[0]), .bus_req_write(wr[0]), .bus_req_address(addr),
    .bus_req_data(wdata), .bus_res_valid(valid[0]), .bus_res_data(rdata[0]),
    .timer_irq(irq[0]), .mtime_lo(mlo[0])
  );

  yarvi_mtimer #(.BASE(BASE), .PRESCALE(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus_req_ready(ready[1]),
    .bus_req_read(rd[1]), .bus_req_write(wr[1]), .bus_req_address(addr),
    .bus_req_data(wdata), .bus_res_valid(valid[1]), .bus_res_data(rdata[1]),
    .timer_irq(irq[1]), .mtime_lo(mlo[1])
  );

  // Response monitor: every read strobe must match the oldest expected entry.
  always begin
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (valid[d] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp dut%0d: got valid=1 data=%h, expected no response", d, rdata[d]);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.dut != d || rdata[d] !== mon_e.data) begin
            errors++;
            $display("FAIL resp_off_%h dut%0d: got %h, expected %h from dut%0d",
                     mon_e.off, d, rdata[d], mon_e.data, mon_e.dut);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input int d, input logic [31:0] off, input logic [31:0] v);
    addr  = BASE + off;
    wdata = v;
    wr[d] = 1'b1;
    @(negedge clock);
    wr[d] = 1'b0;
  endtask

  task automatic bus_read(input int d, input logic [31:0] off, input logic [31:0] exp);
    exp_t e;
    e.dut  = d;
    e.off  = off;
    e.data = exp;
    addr  = BASE + off;
    rd[d] = 1'b1;
    q.push_back(e);
    @(negedge clock);
    rd[d] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input int d);
    chk($sformatf("rst_ready%0d", d), {31'h0, ready[d]}, 32'h0);
    chk($sformatf("rst_valid%0d", d), {31'h0, valid[d]}, 32'h0);
    chk($sformatf("rst_irq%0d", d),   {31'h0, irq[d]},   32'h0);
    chk($sformatf("rst_mlo%0d", d),   mlo[d],            32'h0);
    chk($sformatf("rst_rdata%0d", d), rdata[d],          32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    rd[0] = 1'b0; rd[1] = 1'b0;
    wr[0] = 1'b0; wr[1] = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    repeat (3) @(negedge clock);
    chk_reset_outputs(0);
    chk_reset_outputs(1);

    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_edge1", {31'h0, ready[0]}, 32'h0);
    @(negedge clock);
    chk("ready_edge2", {31'h0, ready[0]}, 32'h1);
    chk("ready_edge2_d1", {31'h0, ready[1]}, 32'h1);

    // Free-running count at PRESCALE=1
    bus_write(0, 32'h10, 32'h1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      chk($sformatf("count_%0d", i), mlo[0], 32'(i));
      chk($sformatf("count_irq_%0d", i), {31'h0, irq[0]}, 32'h0);
    end
    bus_write(0, 32'h10, 32'h0);
    chk("disable_last_tick", mlo[0], 32'd11);
    repeat (2) @(negedge clock);
    chk("frozen", mlo[0], 32'd11);

    // Carry from low word into high word
    bus_write(0, 32'h04, 32'h0);
    bus_write(0, 32'h00, 32'hFFFF_FFFE);
    bus_write(0, 32'h10, 32'h1);
    @(negedge clock);
    chk("carry_lo_ffff", mlo[0], 32'hFFFF_FFFF);
    @(negedge clock);
    bus_write(0, 32'h10, 32'h0);
    bus_read(0, 32'h00, 32'h1);
    bus_read(0, 32'h04, 32'h1);

    // Compare match raises irq, raising mtimecmp clears it
    bus_write(0, 32'h04, 32'h0);
    bus_write(0, 32'h00, 32'h0);
    bus_write(0, 32'h0C, 32'h0);
    bus_write(0, 32'h08, 32'd5);
    bus_write(0, 32'h10, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("cmp_mlo_%0d", k), mlo[0], 32'(k));
      chk($sformatf("cmp_irq_%0d", k), {31'h0, irq[0]}, (k >= 6) ? 32'h1 : 32'h0);
    end
    bus_write(0, 32'h08, 32'd100);
    chk("irq_lag", {31'h0, irq[0]}, 32'h1);
    @(negedge clock);
    chk("irq_cleared", {31'h0, irq[0]}, 32'h0);
    bus_write(0, 32'h10, 32'h0);

    // Decode: unmapped offsets, combined read+write, outside window, byte bits
    bus_read(0, 32'h14, 32'h0);
    bus_read(0, 32'h1C, 32'h0);
    bus_read(0, 32'h10, 32'h0);
    bus_read(0, 32'h08, 32'd100);
    addr  = BASE + 32'h08;
    wdata = 32'h1234;
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    @(negedge clock);
    rd[0] = 1'b0;
    wr[0] = 1'b0;
    bus_read(0, 32'h08, 32'h1234);
    bus_write(0, 32'h28, 32'hDEAD);
    bus_read(0, 32'h28, 32'h0);
    bus_read(0, 32'h09, 32'h1234);
    @(negedge clock);
    chk("res_data_hold", rdata[0], 32'h1234);
    chk("res_valid_low", {31'h0, valid[0]}, 32'h0);

    // mtime write in a tick cycle wins over the increment
    bus_write(0, 32'h10, 32'h1);
    bus_write(0, 32'h00, 32'h100);
    chk("wr_lo_wins", mlo[0], 32'h100);
    @(negedge clock);
    chk("after_wr_lo", mlo[0], 32'h101);
    bus_write(0, 32'h04, 32'h7);
    chk("wr_hi_holds_lo", mlo[0], 32'h101);
    bus_write(0, 32'h10, 32'h0);
    bus_read(0, 32'h00, 32'h102);
    bus_read(0, 32'h04, 32'h7);

    // Full 64-bit wrap
    bus_write(0, 32'h04, 32'hFFFF_FFFF);
    bus_write(0, 32'h00, 32'hFFFF_FFFF);
    bus_write(0, 32'h10, 32'h1);
    bus_write(0, 32'h10, 32'h0);
    bus_read(0, 32'h00, 32'h0);
    bus_read(0, 32'h04, 32'h0);

    // PRESCALE=4: every 4th cycle, disable mid-count restarts the prescaler
    bus_write(1, 32'h10, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk($sformatf("ps4_%0d", k), mlo[1], 32'(k / 4));
    end
    repeat (2) @(negedge clock);
    bus_write(1, 32'h10, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("ps4_frozen_%0d", k), mlo[1], 32'd2);
    end
    bus_write(1, 32'h10, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("ps4_reen_%0d", k), mlo[1], (k == 4) ? 32'd3 : 32'd2);
    end
    bus_read(1, 32'h10, 32'h1);
    bus_write(1, 32'h10, 32'h0);

    // Reset arriving with a read request suppresses the response
    bus_write(0, 32'h00, 32'h2000);
    bus_write(0, 32'h10, 32'h1);
    @(negedge clock);
    chk("pre_reset_irq", {31'h0, irq[0]}, 32'h1);
    bus_read(0, 32'h08, 32'h1234);
    addr    = BASE + 32'h00;
    rd[0]   = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    rd[0] = 1'b0;
    chk_reset_outputs(0);
    chk("mid_reset_ready1", {31'h0, ready[1]}, 32'h0);
    @(negedge clock);
    chk("mid_reset_valid", {31'h0, valid[0]}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rerelease_edge1", {31'h0, ready[0]}, 32'h0);
    @(negedge clock);
    chk("rerelease_edge2", {31'h0, ready[0]}, 32'h1);
    bus_read(0, 32'h08, 32'hFFFF_FFFF);
    bus_read(0, 32'h0C, 32'hFFFF_FFFF);
    bus_read(0, 32'h10, 32'h0);

    repeat (3) @(negedge clock);
    chk("pending_resp", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yarvi_mtimer.md
YARVI_MTIMER -- requirements
Module: yarvi_mtimer

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, word-aligned base address of the 32-byte register window.
REQ-002 SHALL have parameter PRESCALE, default 1, clock cycles per mtime increment; legal range 1..65535.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port bus_req_ready, output, 1, block can accept a request this cycle.
REQ-006 SHALL have port bus_req_read, input, 1, read request.
REQ-007 SHALL have port bus_req_write, input, 1, write request.
REQ-008 SHALL have port bus_req_address, input, 32, byte address.
REQ-009 SHALL have port bus_req_data, input, 32, write data.
REQ-010 SHALL have port bus_res_valid, output, 1, read response strobe.
REQ-011 SHALL have port bus_res_data, output, 32, read response data.
REQ-012 SHALL have port timer_irq, output, 1, machine timer interrupt pending; feeds the core's mip[7].
REQ-013 SHALL have port mtime_lo, output, 32, live mtime[31:0] for the core's time CSR.

Function
REQ-014 Register map, offset from BASE: 0x00 mtime[31:0]; 0x04 mtime[63:32]; 0x08 mtimecmp[31:0]; 0x0C mtimecmp[63:32]; 0x10 ctrl, bit0 = enable, bits 31:1 read 0.
REQ-015 Decode SHALL use bus_req_address[31:5] == BASE[31:5] and bits [4:2]; bits [1:0] ignored.
REQ-016 A request SHALL be accepted when bus_req_ready and (bus_req_read or bus_req_write) are both 1.
REQ-017 bus_req_ready SHALL be registered: 0 during reset, 1 from the second rising edge after reset_n is first sampled 1.
REQ-018 Accepted read: bus_res_valid = 1 for exactly one cycle, the cycle after acceptance; bus_res_data holds the value sampled at acceptance.
REQ-019 bus_res_data SHALL hold its last value when bus_res_valid = 0.
REQ-020 Accepted write SHALL update the target register at the accepting edge; no response generated.
REQ-021 Read and write asserted together SHALL be treated as a write only; no response.
REQ-022 Unmapped address (outside the window, or offsets 0x14..0x1C): read returns 32'h0 with a normal response; write ignored.
REQ-023 Prescaler: counter of width 16 counts 0..PRESCALE-1 while enable = 1; tick occurs on the cycle it equals PRESCALE-1, then it wraps to 0.
REQ-024 On tick, mtime SHALL increment by 1 as a 64-bit value, carrying from bit 31 into bit 32; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-025 enable = 0 SHALL freeze mtime and hold the prescaler at 0.
REQ-026 A write to either mtime half in a tick cycle SHALL win: the written half takes bus_req_data, the other half holds, and no increment occurs that cycle.
REQ-027 Writing ctrl.enable 1->0 SHALL clear the prescaler in the same edge.
REQ-028 timer_irq SHALL be registered: timer_irq <= enable and (mtime >= mtimecmp, unsigned 64-bit), using register values before the current edge's updates.
REQ-029 timer_irq SHALL be level, cleared only by raising mtimecmp, lowering mtime, or clearing enable; one-cycle lag after each.
REQ-030 mtime_lo SHALL equal the mtime[31:0] register directly, no extra latency.

Reset
REQ-031 While reset_n is sampled 0: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, enable = 0, prescaler = 0, bus_req_ready = 0, bus_res_valid = 0, bus_res_data = 0, timer_irq = 0.
REQ-032 Reset asserted with a read response pending SHALL suppress that response: bus_res_valid = 0 in the cycle after the reset edge.

Verification
REQ-033 Reset release, PRESCALE=1, write ctrl=1, then idle 10 cycles -> mtime_lo counts 1..10, one increment per cycle; timer_irq stays 0.
REQ-034 Write mtime_hi=0, mtime_lo=32'hFFFF_FFFE, enable, 3 ticks -> mtime reads 64'h0000_0001_0000_0001 (carry crosses into the high word).
REQ-035 Write mtimecmp=64'd5, mtime=0, enable -> timer_irq rises the cycle after mtime reaches 5; write mtimecmp_lo=100 -> timer_irq falls one cycle later.
REQ-036 PRESCALE=4, enable -> mtime increments every 4th cycle; clear enable mid-count, re-enable -> next increment exactly 4 cycles after re-enable.
REQ-037 Read 0x14 -> bus_res_data=0, bus_res_valid=1 one cycle later; read and write to 0x08 in the same cycle -> mtimecmp_lo updated, no response.
REQ-038 Accept a read, assert reset_n=0 on the next edge -> no bus_res_valid; all outputs at REQ-031 values; bus_req_ready returns to 1 two edges after release.
